// File: rtl/udp_port_demux_pkg.sv
// Shared types for the UDP destination-port demultiplexer.
package udp_port_demux_pkg;

    localparam int MAX_M_COUNT = 16;
    localparam int SEL_W       = $clog2(MAX_M_COUNT);

    typedef logic [15:0] udp_port_t;

    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        DROP
    } state_e;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        udp_port_t   src_port;
        udp_port_t   dest_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_hdr_t;

endpackage

// File: rtl/udp_port_demux_match.sv
// Port lookup: the lowest table index equal to port_i wins.
module udp_port_match
    import udp_port_demux_pkg::*;
#(
    parameter int                        M_COUNT    = 2,
    parameter udp_port_t [0:M_COUNT-1]   PORT_TABLE = {16'd1234, 16'd5678}
) (
    input  udp_port_t        port_i,
    output logic             hit_o,
    output logic [SEL_W-1:0] idx_o
);

    // Walk downwards so the lowest matching entry is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (port_i == PORT_TABLE[i]) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_port_demux.sv
// Routes a UDP header + payload frame to the channel owning its dest port.
module udp_port_demux
    import udp_port_demux_pkg::*;
#(
    parameter int                      M_COUNT        = 2,
    parameter udp_port_t [0:M_COUNT-1] PORT_TABLE     = {16'd1234, 16'd5678},
    parameter bit                      DROP_UNMATCHED = 1'b1,
    parameter int                      DATA_W         = 8,
    parameter int                      KEEP_W         = 1,
    parameter int                      ID_W           = 4,
    parameter int                      DEST_W         = 4,
    parameter int                      USER_W         = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_hdr_valid_i,
    output logic                            s_hdr_ready_o,
    input  udp_hdr_t                        s_hdr_i,
    input  logic                            s_tvalid_i,
    output logic                            s_tready_o,
    input  logic [DATA_W-1:0]               s_tdata_i,
    input  logic [KEEP_W-1:0]               s_tkeep_i,
    input  logic                            s_tlast_i,
    input  logic [ID_W-1:0]                 s_tid_i,
    input  logic [DEST_W-1:0]               s_tdest_i,
    input  logic [USER_W-1:0]               s_tuser_i,
    output logic [M_COUNT-1:0]              m_hdr_valid_o,
    input  logic [M_COUNT-1:0]              m_hdr_ready_i,
    output udp_hdr_t [M_COUNT-1:0]          m_hdr_o,
    output logic [M_COUNT-1:0]              m_tvalid_o,
    input  logic [M_COUNT-1:0]              m_tready_i,
    output logic [M_COUNT-1:0][DATA_W-1:0]  m_tdata_o,
    output logic [M_COUNT-1:0][KEEP_W-1:0]  m_tkeep_o,
    output logic [M_COUNT-1:0]              m_tlast_o,
    output logic [M_COUNT-1:0][ID_W-1:0]    m_tid_o,
    output logic [M_COUNT-1:0][DEST_W-1:0]  m_tdest_o,
    output logic [M_COUNT-1:0][USER_W-1:0]  m_tuser_o,
    output logic                            drop_pulse,
    output logic [15:0]                     drop_count
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [M_COUNT-1:0] hvld_q, hvld_d;
    udp_hdr_t           hdr_q, hdr_d;
    logic               drop_pulse_q, drop_pulse_d;
    logic [15:0]        drop_count_q, drop_count_d;

    logic             hit;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] dst;
    logic             route;
    logic             hdr_fire;
    logic             last_fire;
    logic             sel_tready;

    udp_port_match #(
        .M_COUNT    (M_COUNT),
        .PORT_TABLE (PORT_TABLE)
    ) u_match (
        .port_i (s_hdr_i.dest_port),
        .hit_o  (hit),
        .idx_o  (idx)
    );

    assign route = hit || !DROP_UNMATCHED;
    assign dst   = hit ? idx : SEL_W'(M_COUNT - 1);

    always_comb begin
        sel_tready = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (sel_q == SEL_W'(i)) sel_tready = m_tready_i[i];
        end
    end

    // A new header waits until the previous one has left its channel.
    always_comb begin
        s_hdr_ready_o = !reset && (state_q == IDLE) && (hvld_q == '0);
        s_tready_o    = 1'b0;
        unique case (state_q)
            FORWARD: s_tready_o = sel_tready;
            DROP:    s_tready_o = 1'b1;
            default: s_tready_o = 1'b0;
        endcase
    end

    assign hdr_fire  = s_hdr_valid_i && s_hdr_ready_o;
    assign last_fire = s_tvalid_i && s_tready_o && s_tlast_i;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        hdr_d        = hdr_q;
        hvld_d       = hvld_q & ~m_hdr_ready_i;
        drop_pulse_d = 1'b0;
        drop_count_d = drop_count_q;
        unique case (state_q)
            IDLE: begin
                if (hdr_fire && route) begin
                    state_d = FORWARD;
                    sel_d   = dst;
                    hdr_d   = s_hdr_i;
                    for (int i = 0; i < M_COUNT; i++) begin
                        hvld_d[i] = (dst == SEL_W'(i));
                    end
                end else if (hdr_fire) begin
                    state_d      = DROP;
                    drop_pulse_d = 1'b1;
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                end
            end
            FORWARD, DROP: begin
                if (last_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            hvld_q       <= '0;
            hdr_q        <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            hvld_q       <= hvld_d;
            hdr_q        <= hdr_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Payload is never buffered: the selected channel sees the sink directly.
    always_comb begin
        for (int i = 0; i < M_COUNT; i++) begin
            m_hdr_o[i]    = hdr_q;
            m_tvalid_o[i] = (state_q == FORWARD) && (sel_q == SEL_W'(i))
                            && s_tvalid_i;
            m_tdata_o[i]  = s_tdata_i;
            m_tkeep_o[i]  = s_tkeep_i;
            m_tlast_o[i]  = s_tlast_i;
            m_tid_o[i]    = s_tid_i;
            m_tdest_o[i]  = s_tdest_i;
            m_tuser_o[i]  = s_tuser_i;
        end
    end

    assign m_hdr_valid_o = hvld_q;
    assign drop_pulse    = drop_pulse_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_udp_port_demux.sv
// Scoreboard bench: a dropping instance and a route-unmatched instance.
module tb_udp_port_demux;
    import udp_port_demux_pkg::*;

    typedef logic [18:0] beat_t;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic     hv[2];
    udp_hdr_t hd[2];
    logic     hr[2];
    logic     tv[2];
    beat_t    sb[2];
    logic     tr[2];

    logic [1:0]           mhv[2];
    logic [1:0]           mhr[2] = '{2'b11, 2'b11};
    udp_hdr_t [1:0]       mhd[2];
    logic [1:0]           mtv[2];
    logic [1:0]           mtr[2] = '{2'b11, 2'b11};
    logic [1:0][7:0]      mtd[2];
    logic [1:0][0:0]      mtk[2];
    logic [1:0]           mtl[2];
    logic [1:0][3:0]      mti[2];
    logic [1:0][3:0]      mtde[2];
    logic [1:0][0:0]      mtu[2];
    logic                 dp[2];
    logic [15:0]          dc[2];

    udp_port_demux u_drop (
        .clk(clk), .reset(reset),
        .s_hdr_valid_i(hv[0]), .s_hdr_ready_o(hr[0]), .s_hdr_i(hd[0]),
        .s_tvalid_i(tv[0]), .s_tready_o(tr[0]),
        .s_tdata_i(sb[0][18:11]), .s_tkeep_i(sb[0][10:10]),
        .s_tlast_i(sb[0][9]), .s_tid_i(sb[0][8:5]),
        .s_tdest_i(sb[0][4:1]), .s_tuser_i(sb[0][0:0]),
        .m_hdr_valid_o(mhv[0]), .m_hdr_ready_i(mhr[0]), .m_hdr_o(mhd[0]),
        .m_tvalid_o(mtv[0]), .m_tready_i(mtr[0]),
        .m_tdata_o(mtd[0]), .m_tkeep_o(mtk[0]), .m_tlast_o(mtl[0]),
        .m_tid_o(mti[0]), .m_tdest_o(mtde[0]), .m_tuser_o(mtu[0]),
        .drop_pulse(dp[0]), .drop_count(dc[0])
    );

    udp_port_demux #(
        .PORT_TABLE     ({16'd1234, 16'd1234}),
        .DROP_UNMATCHED (1'b0)
    ) u_fwd (
        .clk(clk), .reset(reset),
        .s_hdr_valid_i(hv[1]), .s_hdr_ready_o(hr[1]), .s_hdr_i(hd[1]),
        .s_tvalid_i(tv[1]), .s_tready_o(tr[1]),
        .s_tdata_i(sb[1][18:11]), .s_tkeep_i(sb[1][10:10]),
        .s_tlast_i(sb[1][9]), .s_tid_i(sb[1][8:5]),
        .s_tdest_i(sb[1][4:1]), .s_tuser_i(sb[1][0:0]),
        .m_hdr_valid_o(mhv[1]), .m_hdr_ready_i(mhr[1]), .m_hdr_o(mhd[1]),
        .m_tvalid_o(mtv[1]), .m_tready_i(mtr[1]),
        .m_tdata_o(mtd[1]), .m_tkeep_o(mtk[1]), .m_tlast_o(mtl[1]),
        .m_tid_o(mti[1]), .m_tdest_o(mtde[1]), .m_tuser_o(mtu[1]),
        .drop_pulse(dp[1]), .drop_count(dc[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    udp_hdr_t exp_h[2][2][$];
    beat_t    exp_b[2][2][$];
    int exp_drops[2] = '{0, 0};
    int pulses[2] = '{0, 0};
    bit force1 = 1'b1;
    bit hold0 = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference routing: first equal table entry, else drop or last channel.
    function automatic int route(input int d, input udp_port_t p);
        udp_port_t t[2];
        t[0] = 16'd1234;
        t[1] = (d == 0) ? 16'd5678 : 16'd1234;
        for (int i = 0; i < 2; i++) if (p == t[i]) return i;
        return (d == 0) ? -1 : 1;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                mhr[d][c] = force1 || ($urandom_range(0, 3) != 0);
                mtr[d][c] = force1 || ($urandom_range(0, 3) != 0);
            end
        end
        if (hold0) mhr[0][0] = 1'b0;
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (dp[d]) pulses[d]++;
            for (int c = 0; c < 2; c++) begin
                if (mhv[d][c] && mhr[d][c]) begin
                    chk("hdr_expected", exp_h[d][c].size() != 0, 1);
                    if (exp_h[d][c].size() != 0)
                        chk("hdr_fields", mhd[d][c], exp_h[d][c].pop_front());
                end
                if (mtv[d][c]) begin
                    chk("beat_expected", exp_b[d][c].size() != 0, 1);
                    if (mtr[d][c] && exp_b[d][c].size() != 0)
                        chk("beat", {mtd[d][c], mtk[d][c], mtl[d][c],
                             mti[d][c], mtde[d][c], mtu[d][c]},
                            exp_b[d][c].pop_front());
                end
            end
        end
    end

    task automatic wait_hdr(input int d, output int w);
        w = 0;
        @(negedge clk);
        while (!hr[d] && w < TMO) begin
            w++;
            @(negedge clk);
        end
        if (w >= TMO) chk("hdr_timeout", hr[d], 1);
    endtask

    task automatic wait_beat(input int d, output int w);
        w = 0;
        @(negedge clk);
        while (!tr[d] && w < TMO) begin
            w++;
            @(negedge clk);
        end
        if (w >= TMO) chk("beat_timeout", tr[d], 1);
    endtask

    function automatic udp_hdr_t rand_hdr(input udp_port_t p);
        udp_hdr_t h;
        h.src_ip    = $urandom;
        h.dst_ip    = $urandom;
        h.src_port  = 16'($urandom);
        h.dest_port = p;
        h.length    = 16'($urandom);
        h.checksum  = 16'($urandom);
        return h;
    endfunction

    task automatic send_frame(input int d, input udp_port_t p, input int n,
                              input bit gaps, output int hw);
        udp_hdr_t h;
        beat_t b;
        int ch, w;
        ch = route(d, p);
        h = rand_hdr(p);
        hd[d] = h;
        hv[d] = 1'b1;
        wait_hdr(d, hw);
        if (ch >= 0) exp_h[d][ch].push_back(h);
        else exp_drops[d]++;
        @(posedge clk);
        #1;
        hv[d] = 1'b0;
        chk("hdr_valid_lat", mhv[d], (ch >= 0) ? (2'b01 << ch) : 2'b00);
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            b = beat_t'($urandom);
            b[9] = (k == n - 1);
            if (ch >= 0) exp_b[d][ch].push_back(b);
            sb[d] = b;
            tv[d] = 1'b1;
            wait_beat(d, w);
            if (ch < 0) chk("drop_tready", w, 0);
            @(posedge clk);
            #1;
            tv[d] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        udp_hdr_t h;
        beat_t b;
        udp_port_t p;
        int hw, w;
        for (int d = 0; d < 2; d++) begin
            hv[d] = 1'b0;
            tv[d] = 1'b0;
            hd[d] = '0;
            sb[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hdr_ready", hr[d], 0);
            chk("rst_tready", tr[d], 0);
            chk("rst_hdr_valid", mhv[d], 0);
            chk("rst_tvalid", mtv[d], 0);
            chk("rst_drop_pulse", dp[d], 0);
            chk("rst_drop_count", dc[d], 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        send_frame(0, 16'd5678, 4, 1'b0, hw);
        send_frame(0, 16'd9999, 3, 1'b0, hw);
        @(negedge clk);
        chk("drop_count_one", dc[0], 1);
        @(posedge clk);
        #1;

        hold0 = 1'b1;
        fork
            begin
                repeat (12) @(posedge clk);
                #1;
                hold0 = 1'b0;
            end
        join_none
        send_frame(0, 16'd1234, 2, 1'b0, hw);
        chk("hdr_still_held", mhv[0][0], 1);
        send_frame(0, 16'd1234, 1, 1'b0, hw);
        chk("hdr_held_off", hw > 0, 1);

        for (int i = 0; i < 6; i++) begin
            send_frame(0, (i % 2 != 0) ? 16'd5678 : 16'd1234, 1, 1'b0, hw);
            if (i > 0) chk("b2b_accept", hw, 0);
        end

        force1 = 1'b0;
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: p = 16'd1234;
                1: p = 16'd5678;
                default: p = 16'($urandom_range(2000, 5000));
            endcase
            send_frame(0, p, $urandom_range(1, 5), 1'b1, hw);
        end
        force1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drop_count", dc[0], exp_drops[0]);
        chk("drop_pulses", pulses[0], exp_drops[0]);
        @(posedge clk);
        #1;

        h = rand_hdr(16'd1234);
        hd[0] = h;
        hv[0] = 1'b1;
        wait_hdr(0, hw);
        exp_h[0][0].push_back(h);
        @(posedge clk);
        #1;
        hv[0] = 1'b0;
        b = beat_t'($urandom);
        b[9] = 1'b0;
        exp_b[0][0].push_back(b);
        sb[0] = b;
        tv[0] = 1'b1;
        wait_beat(0, w);
        @(posedge clk);
        #1;
        b = beat_t'($urandom);
        b[9] = 1'b0;
        sb[0] = b;
        reset = 1'b1;
        #1;
        chk("mid_rst_tready", tr[0], 0);
        chk("mid_rst_tvalid", mtv[0], 0);
        chk("mid_rst_hdr_valid", mhv[0], 0);
        chk("mid_rst_hdr_ready", hr[0], 0);
        chk("mid_rst_drop_count", dc[0], 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_drops = '{0, 0};
        pulses = '{0, 0};
        repeat (3) begin
            @(negedge clk);
            chk("leftover_stall", tr[0], 0);
        end
        @(posedge clk);
        #1;
        tv[0] = 1'b0;
        send_frame(0, 16'd1234, 3, 1'b0, hw);

        send_frame(1, 16'd9999, 3, 1'b0, hw);
        send_frame(1, 16'd1234, 2, 1'b0, hw);
        force1 = 1'b0;
        repeat (15) begin
            case ($urandom_range(0, 2))
                0: p = 16'd1234;
                1: p = 16'd5678;
                default: p = 16'($urandom_range(2000, 5000));
            endcase
            send_frame(1, p, $urandom_range(1, 4), 1'b1, hw);
        end
        force1 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("final_drop_count", dc[d], exp_drops[d]);
            chk("final_pulses", pulses[d], exp_drops[d]);
            for (int c = 0; c < 2; c++) begin
                chk("hdr_left", exp_h[d][c].size(), 0);
                chk("beats_left", exp_b[d][c].size(), 0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
